// File: rtl/cplx_pkg.sv
// Shared types and constants for the complex/real multiply-divide datapath.
// Build option: define CPLX_DIV_ROUND_EN to add one guard-bit iteration
// to the divider and round the quotient to nearest (latency +1 cycle).
package cplx_pkg;

    localparam int CPLX_WIDTH = 32;

`ifdef CPLX_DIV_ROUND_EN
    localparam int LATENCY = CPLX_WIDTH + 4;
`else
    localparam int LATENCY = CPLX_WIDTH + 3;
`endif

    // Divider FSM encoding, kept as plain constants for older tools.
    typedef logic [2:0] state_t;
    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_MUL  = 3'd1;
    localparam state_t ST_SUM  = 3'd2;
    localparam state_t ST_DIV  = 3'd3;
    localparam state_t ST_DONE = 3'd4;

    // Packed {re, im} result shared with the multiplier.
    typedef struct packed {
        logic [CPLX_WIDTH-1:0] re;
        logic [CPLX_WIDTH-1:0] im;
    } cplx_res_t;

    // Quotient bits the divider develops for a given operand width:
    // WIDTH bits, plus one guard bit when rounding is built in.
    function automatic int div_iters(input int width);
        return width + (LATENCY - CPLX_WIDTH - 3);
    endfunction

endpackage

// File: rtl/div_lane.sv
// One restoring-divider lane: q = floor(|n| * 2^WIDTH / den), MSB first,
// with divide-by-zero and overflow pre-checks and a sign applied at the
// output. Build option CPLX_DIV_ROUND_EN adds a guard bit and rounding.
module div_lane
    import cplx_pkg::*;
#(
    parameter int WIDTH = CPLX_WIDTH
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic [WIDTH:0]   i_num,
    input  logic [WIDTH:0]   i_den,
    input  logic             i_neg,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sat,
    output logic             o_dbz
);

    localparam int QW = div_iters(WIDTH);

    logic [WIDTH:0]   r_rem;
    logic [WIDTH:0]   r_den;
    logic [QW-1:0]    r_q;
    logic             r_neg;
    logic             r_sat;
    logic             r_dbz;

    logic [WIDTH+1:0] w_trial;
    logic             w_fit;
    logic             w_den_zero;
    logic             w_too_big;
    logic [WIDTH-1:0] w_iter_q;
    logic [WIDTH-1:0] w_mag;
    logic             w_round_ovf;

    // Shifted partial remainder; it stays below den, so WIDTH+2 bits suffice.
    assign w_trial    = {r_rem, 1'b0};
    assign w_fit      = (w_trial >= {1'b0, r_den});
    assign w_den_zero = (i_den == '0);
    assign w_too_big  = !w_den_zero && (i_num >= i_den);

    // Load operands and flags, then retire one quotient bit per step.
    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values; blocking here would chain r_rem into r_q in one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem <= '0;
            r_den <= '0;
            r_q   <= '0;
            r_neg <= 1'b0;
            r_sat <= 1'b0;
            r_dbz <= 1'b0;
        end else if (i_load) begin
            // A flagged lane iterates on zero; its result is overridden anyway.
            r_rem <= (w_den_zero || w_too_big) ? '0 : i_num;
            r_den <= i_den;
            r_q   <= '0;
            r_neg <= i_neg;
            r_sat <= w_too_big;
            r_dbz <= w_den_zero;
        end else if (i_step) begin
            r_rem <= w_fit ? (WIDTH+1)'(w_trial - {1'b0, r_den}) : w_trial[WIDTH:0];
            r_q   <= {r_q[QW-2:0], w_fit};
        end
    end

`ifdef CPLX_DIV_ROUND_EN
    logic [WIDTH:0] w_rounded;

    // Add the guard bit; a carry out means the quotient clips to all-ones.
    assign w_rounded   = {1'b0, r_q[QW-1:1]} + {{WIDTH{1'b0}}, r_q[0]};
    assign w_round_ovf = w_rounded[WIDTH];
    assign w_iter_q    = w_round_ovf ? '1 : w_rounded[WIDTH-1:0];
`else
    assign w_round_ovf = 1'b0;
    assign w_iter_q    = r_q;
`endif

    assign w_mag = (r_dbz || r_sat) ? '1 : w_iter_q;
    // Negative lanes wrap modulo 2^WIDTH, as the multiplier does on subtraction.
    assign o_q   = r_neg ? (~w_mag + WIDTH'(1)) : w_mag;
    assign o_sat = r_sat || (w_round_ovf && !r_dbz);
    assign o_dbz = r_dbz;

endmodule

// File: rtl/cplx_div.sv
// Iterative Q0.WIDTH unsigned-fraction divider: complex (a+jb)/(c+jd) or two
// independent real quotients, packed {re, im} like the multiplier output.
// Build option: CPLX_DIV_ROUND_EN (guard-bit rounding, one extra cycle).
module cplx_div
    import cplx_pkg::*;
#(
    parameter int WIDTH = CPLX_WIDTH
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               complex_real,
    input  logic [WIDTH-1:0]   Real_A,
    input  logic [WIDTH-1:0]   Real_B,
    input  logic [WIDTH-1:0]   Im_A,
    input  logic [WIDTH-1:0]   Im_B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] out,
    output logic [1:0]         sat,
    output logic [1:0]         dbz
);

    localparam int N_ITER = div_iters(WIDTH);
    localparam int CW     = $clog2(N_ITER);

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_mode;
    logic [WIDTH-1:0]   r_a, r_b, r_c, r_d;
    logic [WIDTH-1:0]   r_ac, r_bd, r_bc, r_ad, r_cc, r_dd;
    logic [2*WIDTH-1:0] r_out;
    logic [1:0]         r_sat;
    logic [1:0]         r_dbz;

    logic [WIDTH:0]     w_den_c, w_nr, w_mag_i;
    logic               w_neg_i;
    logic [WIDTH:0]     w_num_r, w_den_r, w_num_i, w_den_i;
    logic               w_load, w_step;
    logic [WIDTH-1:0]   w_q_r, w_q_i;
    logic               w_sat_r, w_sat_i, w_dbz_r, w_dbz_i;
    logic [2*WIDTH-1:0] w_result;

    // Upper WIDTH bits of a Q0.WIDTH product, truncated as in the multiplier.
    function automatic logic [WIDTH-1:0] mul_hi(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        logic [2*WIDTH-1:0] p;
        p = {{WIDTH{1'b0}}, x} * {{WIDTH{1'b0}}, y};
        return WIDTH'(p >> WIDTH);
    endfunction

    // Capture operands on an accepted start, then form the products in MUL.
    // NOTE: pure datapath registers are not reset; they are always written
    // before use, and leaving them out of reset keeps the reset tree small.
    always_ff @(posedge clock) begin
        if (r_state == ST_IDLE && start) begin
            r_mode <= complex_real;
            r_a    <= Real_A;
            r_b    <= Im_A;
            r_c    <= Real_B;
            r_d    <= Im_B;
        end
        if (r_state == ST_MUL) begin
            r_ac <= mul_hi(r_a, r_c);
            r_bd <= mul_hi(r_b, r_d);
            r_bc <= mul_hi(r_b, r_c);
            r_ad <= mul_hi(r_a, r_d);
            r_cc <= mul_hi(r_c, r_c);
            r_dd <= mul_hi(r_d, r_d);
        end
    end

    // Complex-mode sums; the imaginary numerator is split into sign and magnitude.
    assign w_den_c = {1'b0, r_cc} + {1'b0, r_dd};
    assign w_nr    = {1'b0, r_ac} + {1'b0, r_bd};
    assign w_neg_i = (r_bc < r_ad);
    assign w_mag_i = {1'b0, w_neg_i ? (r_ad - r_bc) : (r_bc - r_ad)};

    // Real mode feeds the registered operands straight to the lanes.
    assign w_num_r = r_mode ? w_nr    : {1'b0, r_a};
    assign w_den_r = r_mode ? w_den_c : {1'b0, r_c};
    assign w_num_i = r_mode ? w_mag_i : {1'b0, r_b};
    assign w_den_i = r_mode ? w_den_c : {1'b0, r_d};

    assign w_load = (r_state == ST_SUM);
    assign w_step = (r_state == ST_DIV);

    div_lane #(.WIDTH(WIDTH)) u_lane_r (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_num  (w_num_r),
        .i_den  (w_den_r),
        .i_neg  (1'b0),
        .o_q    (w_q_r),
        .o_sat  (w_sat_r),
        .o_dbz  (w_dbz_r)
    );

    div_lane #(.WIDTH(WIDTH)) u_lane_i (
        .clock  (clock),
        .reset  (reset),
        .i_load (w_load),
        .i_step (w_step),
        .i_num  (w_num_i),
        .i_den  (w_den_i),
        .i_neg  (r_mode && w_neg_i),
        .o_q    (w_q_i),
        .o_sat  (w_sat_i),
        .o_dbz  (w_dbz_i)
    );

    assign w_result = {w_q_r, w_q_i};

    // Sequence IDLE -> MUL -> SUM -> DIV (N_ITER cycles) -> DONE, and latch the result.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_out   <= '0;
            r_sat   <= '0;
            r_dbz   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_state <= ST_MUL;
                ST_MUL:  r_state <= ST_SUM;
                ST_SUM: begin
                    r_state <= ST_DIV;
                    r_cnt   <= '0;
                end
                ST_DIV: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N_ITER - 1)) r_state <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_out   <= w_result;
                    r_sat   <= {w_sat_r, w_sat_i};
                    r_dbz   <= {w_dbz_r, w_dbz_i};
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // The lanes' final quotient is already valid in DONE; show it there and
    // hold the latched copy afterwards.
    assign out  = (r_state == ST_DONE) ? w_result : r_out;
    assign sat  = (r_state == ST_DONE) ? {w_sat_r, w_sat_i} : r_sat;
    assign dbz  = (r_state == ST_DONE) ? {w_dbz_r, w_dbz_i} : r_dbz;
    assign busy = (r_state == ST_MUL) || (r_state == ST_SUM) || (r_state == ST_DIV);
    assign done = (r_state == ST_DONE);

endmodule

// File: tb/tb_cplx_div.sv
// Self-checking bench for cplx_div: directed vectors, handshake and reset
// behaviour, then randomized operations against an arithmetic reference.
module tb_cplx_div;

    localparam int W = 32;
`ifdef CPLX_DIV_ROUND_EN
    localparam int LAT = 36;
`else
    localparam int LAT = 35;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        complex_real;
    logic [31:0] Real_A, Real_B, Im_A, Im_B;
    logic        busy, done;
    logic [63:0] out;
    logic [1:0]  sat, dbz;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    cplx_div #(.WIDTH(W)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .complex_real (complex_real),
        .Real_A       (Real_A),
        .Real_B       (Real_B),
        .Im_A         (Im_A),
        .Im_B         (Im_B),
        .busy         (busy),
        .done         (done),
        .out          (out),
        .sat          (sat),
        .dbz          (dbz)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference lane: q = floor(n * 2^32 / den) by plain integer division.
    function automatic logic [31:0] ref_lane(input logic [32:0] n, input logic [32:0] den,
                                             input bit neg, output bit s, output bit z);
        logic [127:0] q;
        logic [31:0]  mag;
        s = 1'b0;
        z = 1'b0;
        if (den == 33'd0) begin
            z   = 1'b1;
            mag = 32'hFFFF_FFFF;
        end else if (n >= den) begin
            s   = 1'b1;
            mag = 32'hFFFF_FFFF;
        end else begin
`ifdef CPLX_DIV_ROUND_EN
            q = ({95'd0, n} << 33) / {95'd0, den};
            q = (q >> 1) + (q & 128'd1);
            if (q > 128'hFFFF_FFFF) begin
                s   = 1'b1;
                mag = 32'hFFFF_FFFF;
            end else begin
                mag = q[31:0];
            end
`else
            q   = ({95'd0, n} << 32) / {95'd0, den};
            mag = q[31:0];
`endif
        end
        return neg ? 32'(64'h1_0000_0000 - {32'd0, mag}) : mag;
    endfunction

    task automatic ref_model(input logic mode, input logic [31:0] a, b, c, d,
                             output logic [63:0] o, output logic [1:0] s, output logic [1:0] z);
        logic [63:0] ac, bd, bc, ad, cc, dd, den, nr;
        longint      ni;
        logic [63:0] mag;
        logic [31:0] qr, qi;
        bit          sr, si, zr, zi;
        if (mode) begin
            ac  = (64'(a) * 64'(c)) >> 32;
            bd  = (64'(b) * 64'(d)) >> 32;
            bc  = (64'(b) * 64'(c)) >> 32;
            ad  = (64'(a) * 64'(d)) >> 32;
            cc  = (64'(c) * 64'(c)) >> 32;
            dd  = (64'(d) * 64'(d)) >> 32;
            den = cc + dd;
            nr  = ac + bd;
            ni  = longint'(bc) - longint'(ad);
            mag = (ni < 0) ? 64'(-ni) : 64'(ni);
            qr  = ref_lane(nr[32:0], den[32:0], 1'b0, sr, zr);
            qi  = ref_lane(mag[32:0], den[32:0], ni < 0, si, zi);
        end else begin
            qr = ref_lane({1'b0, a}, {1'b0, c}, 1'b0, sr, zr);
            qi = ref_lane({1'b0, b}, {1'b0, d}, 1'b0, si, zi);
        end
        o = {qr, qi};
        s = {sr, si};
        z = {zr, zi};
    endtask

    task automatic scramble_inputs();
        complex_real = 1'($urandom);
        Real_A = $urandom;
        Real_B = $urandom;
        Im_A   = $urandom;
        Im_B   = $urandom;
    endtask

    // One operation: start, track busy each cycle, time done, check the
    // result, then confirm a start raised during done is ignored.
    task automatic run_op(input string tag, input logic mode, input logic [31:0] a, b, c, d,
                          input logic [63:0] e_out, input logic [1:0] e_sat,
                          input logic [1:0] e_dbz, input int restart_at);
        int n;
        bit seen;
        bit busy_ok;
        @(negedge clock);
        complex_real = mode;
        Real_A = a;
        Im_A   = b;
        Real_B = c;
        Im_B   = d;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        scramble_inputs();
        n = 0;
        seen = 1'b0;
        busy_ok = 1'b1;
        while (!seen && n < LAT + 10) begin
            @(negedge clock);
            n++;
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy !== 1'b1) busy_ok = 1'b0;
                start = (restart_at != 0) && (n == restart_at);
                if (start) scramble_inputs();
            end
        end
        start = 1'b0;
        check({tag, " latency"}, 64'(n), 64'(LAT));
        check({tag, " busy_during"}, 64'(busy_ok), 64'd1);
        check({tag, " busy_at_done"}, 64'(busy), 64'd0);
        check({tag, " out"}, out, e_out);
        check({tag, " sat"}, 64'(sat), 64'(e_sat));
        check({tag, " dbz"}, 64'(dbz), 64'(e_dbz));
        start = 1'b1;
        scramble_inputs();
        @(negedge clock);
        start = 1'b0;
        check({tag, " start_in_done_busy"}, 64'(busy), 64'd0);
        check({tag, " start_in_done_done"}, 64'(done), 64'd0);
        check({tag, " out_held"}, out, e_out);
    endtask

    initial begin
        logic [63:0] e_out;
        logic [1:0]  e_sat, e_dbz;
        logic [31:0] a, b, c, d, t;
        logic        mode;
        bit          no_done;

        reset = 1'b1;
        start = 1'b0;
        complex_real = 1'b0;
        Real_A = '0;
        Real_B = '0;
        Im_A   = '0;
        Im_B   = '0;
        repeat (3) @(negedge clock);
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset out",  out, 64'd0);
        check("reset sat",  64'(sat), 64'd0);
        check("reset dbz",  64'(dbz), 64'd0);
        reset = 1'b0;

        // Directed vectors with hand-derived results.
        run_op("real_basic", 1'b0, 32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 32'h8000_0000,
               64'h8000_0000_4000_0000, 2'b00, 2'b00, 0);
        run_op("cplx_neg_im", 1'b1, 32'h4000_0000, 32'h0, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_C000_0000, 2'b00, 2'b00, 0);
        run_op("cplx_pos_im", 1'b1, 32'h0, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_4000_0000, 2'b00, 2'b00, 0);
        run_op("real_sat", 1'b0, 32'h8000_0000, 32'h2000_0000, 32'h4000_0000, 32'h8000_0000,
               64'hFFFF_FFFF_4000_0000, 2'b10, 2'b00, 0);
        run_op("real_dbz", 1'b0, 32'h4000_0000, 32'h2000_0000, 32'h8000_0000, 32'h0,
               64'h8000_0000_FFFF_FFFF, 2'b00, 2'b01, 0);
`ifdef CPLX_DIV_ROUND_EN
        run_op("round_thirds", 1'b0, 32'h1, 32'h2, 32'h3, 32'h3,
               64'h5555_5555_AAAA_AAAB, 2'b00, 2'b00, 0);
`else
        run_op("trunc_thirds", 1'b0, 32'h1, 32'h2, 32'h3, 32'h3,
               64'h5555_5555_AAAA_AAAA, 2'b00, 2'b00, 0);
`endif

        // Complex divisor whose squares truncate to zero: both lanes divide by zero.
        ref_model(1'b1, 32'h1000_0000, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF, e_out, e_sat, e_dbz);
        run_op("cplx_dbz", 1'b1, 32'h1000_0000, 32'h0, 32'h0000_FFFF, 32'h0000_FFFF,
               e_out, e_sat, e_dbz, 0);

        // A second start at cycle 10 is ignored and the first result stands.
        run_op("restart_ignored", 1'b0, 32'h4000_0000, 32'h2000_0000, 32'h8000_0000,
               32'h8000_0000, 64'h8000_0000_4000_0000, 2'b00, 2'b00, 10);

        // Reset at cycle 20 aborts the operation with no done pulse.
        @(negedge clock);
        complex_real = 1'b1;
        Real_A = 32'h4000_0000;
        Im_A   = 32'h0;
        Real_B = 32'h8000_0000;
        Im_B   = 32'h8000_0000;
        start  = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("abort busy", 64'(busy), 64'd0);
        check("abort out",  out, 64'd0);
        check("abort done", 64'(done), 64'd0);
        reset = 1'b0;
        no_done = 1'b1;
        for (int i = 0; i < LAT + 5; i++) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0) no_done = 1'b0;
        end
        check("abort no_done", 64'(no_done), 64'd1);

        run_op("after_reset", 1'b1, 32'h0, 32'h4000_0000, 32'h8000_0000, 32'h8000_0000,
               64'h4000_0000_4000_0000, 2'b00, 2'b00, 0);

        // Randomized operations against the reference model.
        for (int k = 0; k < 24; k++) begin
            mode = 1'($urandom);
            a = $urandom;
            b = $urandom;
            c = $urandom;
            d = $urandom;
            if (!mode) begin
                if ($urandom_range(0, 3) != 0 && a >= c) begin
                    t = a; a = c; c = t;
                end
                if ($urandom_range(0, 3) != 0 && b >= d) begin
                    t = b; b = d; d = t;
                end
            end else begin
                a = a >> $urandom_range(0, 8);
                b = b >> $urandom_range(0, 8);
            end
            ref_model(mode, a, b, c, d, e_out, e_sat, e_dbz);
            run_op($sformatf("rand%0d", k), mode, a, b, c, d, e_out, e_sat, e_dbz, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
